conv3x3_window_engine: RTL and testbench
========================================

// Module: conv3x3_window_engine
// PURPOSE
// - Downstream consumer of the four 4x4-bit row RAMs (one RAM per image row, address = column).
// - On start, fetches the 4x4 image, then applies a 3x3 kernel to produce the 2x2 valid-region output.
// - Streams the four results in raster order with a valid strobe and pulses done.
// - Sits between the image-store RAMs and the result sink/display stage.
// PARAMETERS
// - DW      4   pixel and kernel-weight width (unsigned)
// - OUT_W   12  result width = 2*DW+4; holds the 9-term sum without overflow (max 9*15*15 = 2025)
// - RD_LAT  1   RAM read latency in cycles, 0 or 1; row_data is valid RD_LAT cycles after rd_addr
// PORTS
// - clk        in   1      clock, rising edge
// - clr_n      in   1      asynchronous, active-low reset
// - start      in   1      begin one frame; sampled only in IDLE
// - kernel     in   9*DW   weights; k(i,j) = kernel[DW*(3*i+j) +: DW]; latched on accepted start
// - rd_addr    out  2      column address, driven in common to all four row RAMs
// - row_data   in   4*DW   RAM data_out; row r pixel = row_data[DW*r +: DW]
// - busy       out  1      high from the cycle after start is accepted through the done cycle
// - pix_valid  out  1      pix_out/pix_row/pix_col are valid this cycle
// - pix_out    out  OUT_W  convolution result
// - pix_row    out  1      output row index, 0..1
// - pix_col    out  1      output column index, 0..1
// - done       out  1      one-cycle pulse after the last result
// BEHAVIOUR
// - Reset (clr_n=0, asynchronous): state=IDLE; rd_addr, busy, pix_valid, pix_out, pix_row, pix_col, done = 0.
//   The 16-entry pixel buffer, latched kernel, and all counters also clear to 0.
// - FSM states: IDLE -> FETCH -> COMPUTE -> DONE -> IDLE.
// - IDLE: rd_addr=0, busy=0. start=1 at edge E latches kernel and moves to FETCH.
//   Cycle E+1 is the first FETCH cycle.
// - FETCH: rd_addr steps 0,1,2,3 on consecutive cycles, then holds 3.
//   Column c (all 4 rows) is captured into the buffer RD_LAT cycles after rd_addr=c.
//   FETCH lasts 4+RD_LAT cycles, then moves to COMPUTE.
// - COMPUTE: 4 cycles, one result per cycle in order (r,c) = (0,0),(0,1),(1,0),(1,1).
//   - out(r,c) = sum over i,j in 0..2 of img(r+i, c+j) * k(i,j).
//   - Unsigned arithmetic; every product and partial sum is zero-extended to OUT_W; no truncation or saturation.
//   - pix_out/pix_row/pix_col/pix_valid are registered: valid is high for exactly 4 consecutive cycles, no gaps.
// - DONE: done=1 and busy=1 for one cycle, pix_valid=0; then IDLE.
// - pix_out holds its last value while pix_valid=0; a consumer must qualify on pix_valid.
// - start while busy: ignored, not queued; kernel changes while busy are ignored.
// - start held high continuously: a new frame begins on the first IDLE cycle after DONE.
//   The minimum frame period is therefore 1 + (4+RD_LAT) + 4 + 1 cycles.
// - Reset mid-frame: the frame aborts immediately; no done pulse. The next start after release runs a full frame.
// - With RD_LAT=1, start to first pix_valid = 6 cycles; with RD_LAT=0, 5 cycles.
// TESTING
// - All pixels=1, all weights=1, RD_LAT=1
//   -> pix_out = 9,9,9,9 at (0,0),(0,1),(1,0),(1,1).
//   -> first pix_valid 6 cycles after start; done 1 cycle after last valid.
// - Image pixel(r,c)=4r+c; kernel centre k(1,1)=1, all other weights 0
//   -> pix_out = 5,6,9,10.
// - All pixels=15, all weights=15 -> pix_out = 2025 each (no overflow); busy high exactly 10 cycles.
// - start re-pulsed during FETCH and COMPUTE, with kernel changed mid-frame
//   -> outputs unchanged from the original kernel; exactly 4 valids and one done.
// - clr_n pulsed low during FETCH -> all outputs 0, state IDLE, no done.
//   -> a subsequent start produces correct results, with no stale pixels from the aborted frame.
// - RD_LAT=0 build, ramp image, all weights=1 -> pix_out = 45,54,81,90; first valid 5 cycles after start.

Source files
------------

// File: rtl/conv3x3_window_engine_if.sv
// rtl/conv3x3_window_engine_if.sv - start/kernel, row-RAM read port and result stream of the 3x3 window engine
interface conv3x3_window_engine_if #(
  parameter int DW    = 4,
  parameter int OUT_W = 2*DW+4
);
  logic             start;
  logic [9*DW-1:0]  kernel;
  logic [1:0]       rd_addr;
  logic [4*DW-1:0]  row_data;
  logic             busy;
  logic             pix_valid;
  logic [OUT_W-1:0] pix_out;
  logic             pix_row;
  logic             pix_col;
  logic             done;

  modport slave (
    input  start, kernel, row_data,
    output rd_addr, busy, pix_valid, pix_out, pix_row, pix_col, done
  );

  modport master (
    output start, kernel, row_data,
    input  rd_addr, busy, pix_valid, pix_out, pix_row, pix_col, done
  );
endinterface

// File: rtl/conv3x3_window_engine.sv
// rtl/conv3x3_window_engine.sv - fetches a 4x4 image column by column and streams the 2x2 3x3-convolution results
module conv3x3_window_engine #(
  parameter int DW     = 4,
  parameter int OUT_W  = 2*DW+4,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    clr_n,
  conv3x3_window_engine_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_COMPUTE, S_DONE} state_t;

  localparam logic [2:0] FETCH_LAST = 3'(3 + RD_LAT);
  localparam logic [2:0] CAP_OFS    = 3'(RD_LAT);

  state_t            state_q, state_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic [1:0]        oidx_q, oidx_d;
  logic [9*DW-1:0]   kern_q, kern_d;
  logic [16*DW-1:0]  pix_q, pix_d;
  logic [1:0]        rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              pix_valid_q, pix_valid_d;
  logic [OUT_W-1:0]  pix_out_q, pix_out_d;
  logic              pix_row_q, pix_row_d;
  logic              pix_col_q, pix_col_d;
  logic              done_q, done_d;

  logic [1:0]        sel_idx;
  logic [1:0]        cap_col;
  logic              cap_en;
  logic [OUT_W-1:0]  conv_sum;

  // Outputs are registered, so the result being computed is one ahead of the one on the bus:
  // result 0 is computed in the last FETCH cycle, results 1..3 in COMPUTE.
  assign sel_idx = (state_q == S_FETCH) ? 2'd0 : oidx_q;
  assign cap_col = 2'(fcnt_q - CAP_OFS);
  assign cap_en  = (RD_LAT == 0) || (fcnt_q != 3'd0);

  always_comb begin
    conv_sum = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        conv_sum = conv_sum
                 + OUT_W'(pix_q[DW*(4*(int'(sel_idx[1]) + i) + int'(sel_idx[0]) + j) +: DW])
                 * OUT_W'(kern_q[DW*(3*i + j) +: DW]);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    oidx_d      = oidx_q;
    kern_d      = kern_q;
    pix_d       = pix_q;
    rd_addr_d   = rd_addr_q;
    busy_d      = busy_q;
    pix_valid_d = 1'b0;
    pix_out_d   = pix_out_q;
    pix_row_d   = pix_row_q;
    pix_col_d   = pix_col_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        rd_addr_d = 2'd0;
        busy_d    = 1'b0;
        if (bus.start) begin
          kern_d  = bus.kernel;
          state_d = S_FETCH;
          fcnt_d  = 3'd0;
          oidx_d  = 2'd0;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        rd_addr_d = (rd_addr_q == 2'd3) ? 2'd3 : rd_addr_q + 2'd1;
        if (cap_en) begin
          for (int r = 0; r < 4; r++) begin
            pix_d[DW*(4*r + int'(cap_col)) +: DW] = bus.row_data[DW*r +: DW];
          end
        end
        fcnt_d = fcnt_q + 3'd1;
        if (fcnt_q == FETCH_LAST) begin
          state_d     = S_COMPUTE;
          pix_valid_d = 1'b1;
          pix_out_d   = conv_sum;
          pix_row_d   = sel_idx[1];
          pix_col_d   = sel_idx[0];
          oidx_d      = 2'd1;
        end
      end
      S_COMPUTE: begin
        if (oidx_q != 2'd0) begin
          pix_valid_d = 1'b1;
          pix_out_d   = conv_sum;
          pix_row_d   = sel_idx[1];
          pix_col_d   = sel_idx[0];
          oidx_d      = oidx_q + 2'd1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        rd_addr_d = 2'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= S_IDLE;
      fcnt_q      <= '0;
      oidx_q      <= '0;
      kern_q      <= '0;
      pix_q       <= '0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_out_q   <= '0;
      pix_row_q   <= 1'b0;
      pix_col_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      oidx_q      <= oidx_d;
      kern_q      <= kern_d;
      pix_q       <= pix_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= busy_d;
      pix_valid_q <= pix_valid_d;
      pix_out_q   <= pix_out_d;
      pix_row_q   <= pix_row_d;
      pix_col_q   <= pix_col_d;
      done_q      <= done_d;
    end
  end

  assign bus.rd_addr   = rd_addr_q;
  assign bus.busy      = busy_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_out   = pix_out_q;
  assign bus.pix_row   = pix_row_q;
  assign bus.pix_col   = pix_col_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_conv3x3_window_engine.sv
// tb/tb_conv3x3_window_engine.sv - scoreboard bench for RD_LAT=0 and RD_LAT=1 builds of the window engine
module tb_conv3x3_window_engine;
  localparam int DW    = 4;
  localparam int OUT_W = 12;

  logic clk;
  logic clr_n;
  logic start;
  logic [9*DW-1:0] kern;
  logic [3:0] img [16];
  int cyc = 0;

  conv3x3_window_engine_if #(.DW(DW), .OUT_W(OUT_W)) b0 ();
  conv3x3_window_engine_if #(.DW(DW), .OUT_W(OUT_W)) b1 ();

  conv3x3_window_engine #(.DW(DW), .OUT_W(OUT_W), .RD_LAT(0)) u0 (.clk(clk), .clr_n(clr_n), .bus(b0.slave));
  conv3x3_window_engine #(.DW(DW), .OUT_W(OUT_W), .RD_LAT(1)) u1 (.clk(clk), .clr_n(clr_n), .bus(b1.slave));

  assign b0.start  = start;
  assign b1.start  = start;
  assign b0.kernel = kern;
  assign b1.kernel = kern;

  // Row RAMs: combinational read for the RD_LAT=0 build, one-cycle registered read for RD_LAT=1.
  always_comb begin
    b0.row_data = '0;
    for (int r = 0; r < 4; r++) b0.row_data[4*r +: 4] = img[4*r + int'(b0.rd_addr)];
  end
  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) b1.row_data[4*r +: 4] <= img[4*r + int'(b1.rd_addr)];
  end

  logic pv [2], bz [2], dn [2], pr [2], pc [2];
  logic [OUT_W-1:0] po [2];
  logic [1:0] ra [2];
  assign pv[0] = b0.pix_valid; assign pv[1] = b1.pix_valid;
  assign bz[0] = b0.busy;      assign bz[1] = b1.busy;
  assign dn[0] = b0.done;      assign dn[1] = b1.done;
  assign pr[0] = b0.pix_row;   assign pr[1] = b1.pix_row;
  assign pc[0] = b0.pix_col;   assign pc[1] = b1.pix_col;
  assign po[0] = b0.pix_out;   assign po[1] = b1.pix_out;
  assign ra[0] = b0.rd_addr;   assign ra[1] = b1.rd_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  int start_cyc = 0;
  int done_cnt [2];
  int vcnt [2];
  int bcnt [2];
  int last_val [2];
  logic [13:0] exp_q [2][$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int ref_out(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(img[4*(r+i) + c + j]) * int'(kern[4*(3*i+j) +: 4]);
    return s;
  endfunction

  // Monitor: pops the scoreboard on every valid result and audits frame timing on done.
  always @(negedge clk) begin
    if (clr_n) begin
      for (int d = 0; d < 2; d++) begin
        if (bz[d]) bcnt[d]++;
        if (pv[d]) begin
          if (vcnt[d] == 0) chk($sformatf("first_valid_latency[lat%0d]", d), cyc - start_cyc, 5 + d);
          if (exp_q[d].size() == 0) begin
            chk($sformatf("unexpected_valid[lat%0d]", d), 1, 0);
          end else begin
            logic [13:0] e;
            e = exp_q[d].pop_front();
            chk($sformatf("pix_out[lat%0d]", d), int'(po[d]), int'(e[11:0]));
            chk($sformatf("pix_row[lat%0d]", d), int'(pr[d]), int'(e[13]));
            chk($sformatf("pix_col[lat%0d]", d), int'(pc[d]), int'(e[12]));
            last_val[d] = int'(e[11:0]);
          end
          vcnt[d]++;
        end
        if (dn[d]) begin
          chk($sformatf("valid_count[lat%0d]", d), vcnt[d], 4);
          chk($sformatf("busy_cycles[lat%0d]", d), bcnt[d], 9 + d);
          chk($sformatf("done_latency[lat%0d]", d), cyc - start_cyc, 9 + d);
          chk($sformatf("done_busy[lat%0d]", d), int'(bz[d]), 1);
          chk($sformatf("pix_out_hold[lat%0d]", d), int'(po[d]), last_val[d]);
          done_cnt[d]++;
          vcnt[d] = 0;
          bcnt[d] = 0;
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_rd_addr[lat%0d]", tag, d), int'(ra[d]), 0);
      chk($sformatf("%s_busy[lat%0d]", tag, d), int'(bz[d]), 0);
      chk($sformatf("%s_pix_valid[lat%0d]", tag, d), int'(pv[d]), 0);
      chk($sformatf("%s_pix_out[lat%0d]", tag, d), int'(po[d]), 0);
      chk($sformatf("%s_pix_row[lat%0d]", tag, d), int'(pr[d]), 0);
      chk($sformatf("%s_pix_col[lat%0d]", tag, d), int'(pc[d]), 0);
      chk($sformatf("%s_done[lat%0d]", tag, d), int'(dn[d]), 0);
    end
  endtask

  task automatic wait_frames();
    int t = 0;
    while ((done_cnt[0] < frames || done_cnt[1] < frames) && t < 60) begin
      @(posedge clk);
      t++;
    end
    chk("frame_timeout", int'(t < 60), 1);
  endtask

  task automatic run_frame(input bit repulse);
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        for (int d = 0; d < 2; d++)
          exp_q[d].push_back({1'(r), 1'(c), 12'(ref_out(r, c))});
    start = 1'b1;
    start_cyc = cyc;
    frames++;
    @(posedge clk); #1;
    start = 1'b0;
    if (repulse) begin
      @(posedge clk); #1;
      kern = {$urandom, $urandom};
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      kern = {$urandom, $urandom};
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_frames();
  endtask

  task automatic set_img_ramp();
    for (int p = 0; p < 16; p++) img[p] = 4'(p);
  endtask

  task automatic set_img_const(input logic [3:0] v);
    for (int p = 0; p < 16; p++) img[p] = v;
  endtask

  task automatic set_kern_const(input logic [3:0] v);
    for (int k = 0; k < 9; k++) kern[4*k +: 4] = v;
  endtask

  initial begin
    clr_n = 1'b0;
    start = 1'b0;
    kern  = '0;
    set_img_const(4'd0);
    for (int d = 0; d < 2; d++) begin
      done_cnt[d] = 0; vcnt[d] = 0; bcnt[d] = 0; last_val[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    clr_n = 1'b1;
    repeat (2) @(posedge clk);

    set_img_const(4'd1);  set_kern_const(4'd1);  run_frame(1'b0);
    set_img_ramp();       set_kern_const(4'd0);  kern[4*4 +: 4] = 4'd1; run_frame(1'b0);
    set_img_const(4'd15); set_kern_const(4'd15); run_frame(1'b0);
    set_img_ramp();       set_kern_const(4'd1);  run_frame(1'b0);
    for (int p = 0; p < 16; p++) img[p] = 4'($urandom_range(0, 15));
    kern = {$urandom, $urandom};
    run_frame(1'b1);

    // Abort during FETCH, then refetch a different image.
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    clr_n = 1'b0;
    @(negedge clk);
    check_zero("abort");
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete(); vcnt[d] = 0; bcnt[d] = 0;
    end
    @(posedge clk); #1;
    clr_n = 1'b1;
    repeat (15) @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort_no_done[lat%0d]", d), done_cnt[d], frames);
      chk($sformatf("abort_idle_busy[lat%0d]", d), int'(bz[d]), 0);
    end
    for (int p = 0; p < 16; p++) img[p] = 4'(15 - p);
    set_kern_const(4'd2);
    run_frame(1'b0);

    for (int n = 0; n < 20; n++) begin
      for (int p = 0; p < 16; p++) img[p] = 4'($urandom_range(0, 15));
      kern = {$urandom, $urandom};
      run_frame(n % 5 == 0);
    end

    repeat (5) @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("total_done[lat%0d]", d), done_cnt[d], frames);
      chk($sformatf("scoreboard_empty[lat%0d]", d), exp_q[d].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
